// File: rtl/keyboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keyboard_pkg
//  Description : Shared geometry, state encoding and helpers for the
//                keyboard matrix scanner and its debounce bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package keyboard_pkg;

  localparam int KB_COLS = 8;
  localparam int KB_ROWS = 7;
  localparam int COL_W   = $clog2(KB_COLS);

  // One column's worth of key states, bit r = row r
  typedef logic [KB_ROWS-1:0] row_t;

  // Scanner sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_SAMPLE  = 2'd2,
    ST_PUBLISH = 2'd3
  } scan_state_t;

  // One-hot column pattern for a column index
  function automatic logic [KB_COLS-1:0] col_onehot(input logic [COL_W-1:0] c);
    logic [KB_COLS-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_bank
//  Description : Stable state and debounce counter for every key of the
//                matrix. Only the addressed column is evaluated/updated.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_bank
  import keyboard_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3,
  parameter int CNT_W          = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [COL_W-1:0] col,
  input  row_t             sample,
  input  logic             update,
  output row_t             stable_row,
  output row_t             flip
);

  localparam logic [CNT_W:0] DB_LAST = (CNT_W+1)'(DEBOUNCE_SCANS);

  row_t             stable [KB_COLS];
  logic [CNT_W-1:0] cnt    [KB_COLS][KB_ROWS];
  logic [CNT_W-1:0] cnt_next [KB_ROWS];

  // Next stable row / counters of the addressed column; stable_row already
  // reflects this sample so the publisher sees the post-update state.
  always_comb begin
    stable_row = stable[col];
    flip       = '0;
    for (int r = 0; r < KB_ROWS; r++) begin
      cnt_next[r] = cnt[col][r];
      if (sample[r] == stable[col][r]) begin
        cnt_next[r] = '0;
      end else if (({1'b0, cnt[col][r]} + (CNT_W+1)'(1)) == DB_LAST) begin
        stable_row[r] = sample[r];
        flip[r]       = 1'b1;
        cnt_next[r]   = '0;
      end else begin
        cnt_next[r] = cnt[col][r] + CNT_W'(1);
      end
    end
  end

  // Commit the addressed column only when the scanner is sampling it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < KB_COLS; c++) begin
        stable[c] <= '0;
        for (int r = 0; r < KB_ROWS; r++) begin
          cnt[c][r] <= '0;
        end
      end
    end else if (update) begin
      stable[col] <= stable_row;
      for (int r = 0; r < KB_ROWS; r++) begin
        cnt[col][r] <= cnt_next[r];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/keyboard_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keyboard_matrix_scanner
//  Description : Drives one-hot matrix columns, samples active-low rows after
//                a settle delay, debounces each key and publishes one column
//                per read strobe to the keyboard register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module keyboard_matrix_scanner
  import keyboard_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int CNT_W          = 2
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Enable,
  input  logic [KB_ROWS-1:0] kbRowRaw,
  output logic [KB_COLS-1:0] kbColDrive,
  output logic [KB_COLS-1:0] kbCol,
  output logic [KB_ROWS-1:0] kbRow,
  output logic               read,
  output logic               keyChanged,
  output logic               scanDone
);

  localparam int               SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST    = COL_W'(KB_COLS - 1);

  scan_state_t      state;
  logic [COL_W-1:0] col;
  logic [SET_W-1:0] settle_cnt;
  row_t             pressed;
  row_t             stable_row;
  row_t             flip;
  logic             sampling;

  // Rows are active-low on the matrix; the bank works in pressed = 1 terms
  assign pressed  = ~kbRowRaw;
  assign sampling = (state == ST_SAMPLE);

  key_debounce_bank #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .col        (col),
    .sample     (pressed),
    .update     (sampling),
    .stable_row (stable_row),
    .flip       (flip)
  );

  // Scan sequencer with registered column drive and publish outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= ST_IDLE;
      col        <= '0;
      settle_cnt <= '0;
      kbColDrive <= '0;
      kbCol      <= '0;
      kbRow      <= '0;
      read       <= 1'b0;
      keyChanged <= 1'b0;
      scanDone   <= 1'b0;
    end else begin
      read       <= 1'b0;
      keyChanged <= 1'b0;
      scanDone   <= 1'b0;
      kbCol      <= '0;
      case (state)
        ST_IDLE: begin
          kbColDrive <= '0;
          if (Enable) begin
            state      <= ST_DRIVE;
            col        <= '0;
            settle_cnt <= '0;
            kbColDrive <= col_onehot('0);
          end
        end
        ST_DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        ST_SAMPLE: begin
          // Debounce bank commits on this edge; publish its post-update view
          state      <= ST_PUBLISH;
          read       <= 1'b1;
          kbCol      <= col_onehot(col);
          kbRow      <= stable_row;
          keyChanged <= |flip;
          scanDone   <= (col == COL_LAST);
        end
        ST_PUBLISH: begin
          if (Enable) begin
            state      <= ST_DRIVE;
            col        <= col + COL_W'(1);
            settle_cnt <= '0;
            kbColDrive <= col_onehot(col + COL_W'(1));
          end else begin
            state      <= ST_IDLE;
            col        <= '0;
            kbColDrive <= '0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          col        <= '0;
          kbColDrive <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keyboard_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keyboard_matrix_scanner
//  Description : Self-checking bench for keyboard_matrix_scanner with a
//                diode-matrix model driving the row lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keyboard_matrix_scanner;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Enable;
  logic [6:0] kbRowRaw;
  logic [7:0] kbColDrive;
  logic [7:0] kbCol;
  logic [6:0] kbRow;
  logic       read;
  logic       keyChanged;
  logic       scanDone;

  logic [6:0] keys [8];
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [55:0] mat;
    logic [7:0]  col;
    logic [6:0]  row;
    logic        chg;
    logic        done;
  } vec_t;

  vec_t vecs [56];

  keyboard_matrix_scanner dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Enable     (Enable),
    .kbRowRaw   (kbRowRaw),
    .kbColDrive (kbColDrive),
    .kbCol      (kbCol),
    .kbRow      (kbRow),
    .read       (read),
    .keyChanged (keyChanged),
    .scanDone   (scanDone)
  );

  always #5 Clk = ~Clk;

  // Matrix model: a driven column pulls low the rows of its pressed keys
  always_comb begin
    kbRowRaw = 7'h7F;
    for (int c = 0; c < 8; c++) begin
      if (kbColDrive[c]) kbRowRaw = kbRowRaw & ~keys[c];
    end
  end

  function automatic logic [55:0] key(input int c, input int r);
    logic [55:0] one;
    one = 56'd1;
    return one << (c * 7 + r);
  endfunction

  task automatic set_matrix(input logic [55:0] m);
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 7; r++)
        keys[c][r] = m[c*7+r];
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for the next read strobe; flags stray outputs meanwhile
  task automatic wait_read(input string name, output int cyc);
    logic ok;
    logic stray;
    ok    = 1'b0;
    stray = 1'b0;
    cyc   = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (read) begin
        cyc = i;
        ok  = 1'b1;
        break;
      end
      if (kbCol != 8'h00 || keyChanged || scanDone) stray = 1'b1;
    end
    check({name, " read seen"}, 64'(ok), 64'd1);
    check({name, " quiet outside read"}, 64'(stray), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n6;
    int nreads;
    logic [55:0] k21, k54, k00, k06, k60;
    logic [6:0] exp6 [3];
    logic       expc6 [3];

    k21 = key(2, 1);
    k54 = key(5, 4);
    k00 = key(0, 0);
    k06 = key(0, 6);
    k60 = key(6, 0);
    exp6[0] = 7'h00; exp6[1] = 7'h00; exp6[2] = 7'h01;
    expc6[0] = 1'b0; expc6[1] = 1'b0; expc6[2] = 1'b1;

    // Seven scans: (2,1) held then released, bounce on (5,4), (0,0)+(0,6) together
    for (int s = 0; s < 7; s++) begin
      for (int c = 0; c < 8; c++) begin
        vecs[s*8+c].mat  = (s < 4 ? k21 : 56'd0) | (s != 2 ? k54 : 56'd0) |
                           (s >= 4 ? (k00 | k06) : 56'd0);
        vecs[s*8+c].col  = 8'h01 << c;
        vecs[s*8+c].row  = 7'h00;
        vecs[s*8+c].chg  = 1'b0;
        vecs[s*8+c].done = (c == 7);
      end
    end
    vecs[2*8+2].row = 7'h02; vecs[2*8+2].chg = 1'b1;
    vecs[3*8+2].row = 7'h02;
    vecs[4*8+2].row = 7'h02;
    vecs[5*8+2].row = 7'h02;
    vecs[6*8+2].row = 7'h00; vecs[6*8+2].chg = 1'b1;
    vecs[5*8+5].row = 7'h10; vecs[5*8+5].chg = 1'b1;
    vecs[6*8+5].row = 7'h10;
    vecs[6*8+0].row = 7'h41; vecs[6*8+0].chg = 1'b1;

    // Reset state
    set_matrix(56'd0);
    Rst_n  = 1'b0;
    Enable = 1'b1;
    repeat (3) @(negedge Clk);
    check("reset kbColDrive", 64'(kbColDrive), 64'h0);
    check("reset kbCol", 64'(kbCol), 64'h0);
    check("reset kbRow", 64'(kbRow), 64'h0);
    check("reset strobes", 64'({read, keyChanged, scanDone}), 64'h0);
    Rst_n = 1'b1;

    // Table-driven scan vectors
    for (int i = 0; i < 56; i++) begin
      set_matrix(vecs[i].mat);
      wait_read($sformatf("vec%0d", i), cyc);
      check($sformatf("vec%0d period", i), 64'(cyc), 64'd6);
      check($sformatf("vec%0d kbCol", i), 64'(kbCol), 64'(vecs[i].col));
      check($sformatf("vec%0d kbRow", i), 64'(kbRow), 64'(vecs[i].row));
      check($sformatf("vec%0d keyChanged", i), 64'(keyChanged), 64'(vecs[i].chg));
      check($sformatf("vec%0d scanDone", i), 64'(scanDone), 64'(vecs[i].done));
    end

    // Enable dropped during DRIVE of column 3
    set_matrix(56'd0);
    for (int i = 0; i < 3; i++) wait_read("pre-drop", cyc);
    check("pre-drop col2", 64'(kbCol), 64'h04);
    repeat (2) @(negedge Clk);
    Enable = 1'b0;
    wait_read("drop", cyc);
    check("drop col3 read", 64'(kbCol), 64'h08);
    @(negedge Clk);
    check("drop drive idle", 64'(kbColDrive), 64'h0);
    nreads = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (read) nreads++;
    end
    check("drop no reads", 64'(nreads), 64'd0);
    check("drop drive still idle", 64'(kbColDrive), 64'h0);
    set_matrix(k60);
    Enable = 1'b1;
    wait_read("reenable", cyc);
    check("reenable col0", 64'(kbCol), 64'h01);

    // Debounce key (6,0) to pressed
    n6 = 0;
    for (int i = 0; i < 30 && n6 < 3; i++) begin
      wait_read("prep60", cyc);
      if (kbCol == 8'h40) begin
        check($sformatf("prep60 kbRow%0d", n6), 64'(kbRow), 64'(exp6[n6]));
        check($sformatf("prep60 chg%0d", n6), 64'(keyChanged), 64'(expc6[n6]));
        n6++;
      end
    end
    check("prep60 col6 reads", 64'(n6), 64'd3);

    // Reset during SAMPLE of column 6
    for (int i = 0; i < 10; i++) begin
      wait_read("to col5", cyc);
      if (kbCol == 8'h20) break;
    end
    check("at col5", 64'(kbCol), 64'h20);
    repeat (5) @(negedge Clk);
    check("sample col6 drive", 64'(kbColDrive), 64'h40);
    Rst_n = 1'b0;
    #1;
    check("async reset drive", 64'(kbColDrive), 64'h0);
    check("async reset read", 64'(read), 64'd0);
    check("async reset kbRow", 64'(kbRow), 64'h0);
    @(negedge Clk);
    check("in reset read", 64'(read), 64'd0);
    Rst_n = 1'b1;
    wait_read("post-reset", cyc);
    check("post-reset col0", 64'(kbCol), 64'h01);
    check("post-reset period", 64'(cyc), 64'd6);
    n6 = 0;
    for (int i = 0; i < 30 && n6 < 3; i++) begin
      wait_read("post60", cyc);
      if (kbCol == 8'h40) begin
        check($sformatf("post60 kbRow%0d", n6), 64'(kbRow), 64'(exp6[n6]));
        check($sformatf("post60 chg%0d", n6), 64'(keyChanged), 64'(expc6[n6]));
        n6++;
      end
    end
    check("post60 col6 reads", 64'(n6), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keyboard_matrix_scanner.md
Name: keyboard_matrix_scanner

Overview:
Upstream stage of the keyboard state register file. It drives the 8 one-hot column lines of the 8x7 key matrix and samples the 7 active-low row lines after a settle delay. It debounces every key independently, then presents the column select, debounced row vector and a one-cycle read strobe to the keyboard register file. One full scan refreshes all 56 key states.

Parameters:
SETTLE_CYCLES, 4, cycles a column is driven before rows are sampled (>=1)
DEBOUNCE_SCANS, 3, consecutive differing samples required to flip a key's stable state (>=1)
CNT_W, 2, width of per-key debounce counter; must hold DEBOUNCE_SCANS

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
Enable  in  1  scanning enabled
kbRowRaw  in  7  matrix row lines, active-low (0 = pressed)
kbColDrive  out  8  one-hot column drive to matrix; all-zero when idle
kbCol  out  8  one-hot column select to register file, valid with read
kbRow  out  7  debounced row state (1 = pressed) of column kbCol, valid with read
read  out  1  one-cycle write strobe into keyboard register file
keyChanged  out  1  one-cycle pulse with read when any key of this column flipped
scanDone  out  1  one-cycle pulse with read of column 7

Behaviour:
- Clock and reset: single clock Clk; Rst_n asynchronous, active-low. All flops clear immediately on Rst_n low.
- Reset values:
  - state IDLE, column index 0.
  - kbColDrive, kbCol, kbRow = 0.
  - read, keyChanged, scanDone = 0.
  - All stable key states and debounce counters = 0.
- FSM states: IDLE, DRIVE, SAMPLE, PUBLISH.
  - IDLE: kbColDrive = 0. If Enable, go to DRIVE with column 0 and settle counter 0.
  - DRIVE: kbColDrive = 1<<col. Settle counter increments. After SETTLE_CYCLES cycles in DRIVE, go to SAMPLE.
  - SAMPLE (1 cycle): kbColDrive is still driven. Register pressed = ~kbRowRaw and update debounce for the 7 keys of col.
  - PUBLISH (1 cycle): read = 1, kbCol = 1<<col, kbRow = stable[col] (already updated). keyChanged = 1 if any bit of the column flipped in SAMPLE. scanDone = 1 if col == 7.
    - Column advance: col wraps 7 -> 0.
    - Next state: DRIVE if Enable, else IDLE with col reset to 0.
- Timing: column period is SETTLE_CYCLES+2 cycles; full scan is 8*(SETTLE_CYCLES+2) cycles (48 at defaults).
- Debounce rule, per key (c,r), evaluated only in SAMPLE of column c:
  - sample == stable: cnt <= 0.
  - sample != stable and cnt+1 == DEBOUNCE_SCANS: stable <= sample, cnt <= 0, flip flagged.
  - otherwise: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_SCANS scans never changes stable.
- Output validity: kbCol and kbRow are valid only while read = 1. Outside PUBLISH, kbCol = 0 and kbRow holds its last value.
- Enable deasserted mid-column: the current column completes through PUBLISH (read still issued), then the block goes to IDLE. Debounce state is kept. Re-enable restarts at column 0.
- Reset mid-operation: immediate return to reset values.
  - kbColDrive drops to 0 asynchronously.
  - No partial read is issued; the downstream register file is cleared by the same reset.
- Simultaneous press and release within one column: all 7 keys are handled independently in the same SAMPLE cycle. keyChanged is the OR of their flips.
- Only row bits [4:0] are consumed downstream today. Rows 5-6 are scanned and debounced identically.

Decomposition:
- Shared package keyboard_pkg holds:
  - KB_COLS = 8, KB_ROWS = 7.
  - The scanner state enum type.
  - A typedef for a row vector.
- Sub-module key_debounce_bank (one instance) holds:
  - KB_COLS x KB_ROWS stable bits and CNT_W counters.
  - Inputs: col index, sample vector, update enable.
  - Outputs: stable row of the selected column and a flip vector.
- The FSM and column counter stay in the top module.

Test Plan:
- Reset, then Enable=1, no keys pressed (kbRowRaw=7'h7F), defaults:
  - read pulses every 6 cycles with kbCol = 01,02,...,80.
  - kbRow = 0 and keyChanged = 0 throughout.
  - scanDone pulses once per 48 cycles, with kbCol = 80.
- Key (col 2, row 1) held pressed continuously from time 0:
  - kbRow = 7'h02 with keyChanged = 1 first appears on the 3rd read of column 2.
  - Later scans show 7'h02 with keyChanged = 0.
  - Release: bit 1 clears after 3 further scans of column 2.
- Bounce on (col 5, row 4): pressed for 2 scans, released for 1, pressed for 3:
  - Stable flips only after the final 3 consecutive pressed samples.
  - kbRow = 7'h10 with keyChanged = 1 exactly once.
- Enable dropped during DRIVE of column 3:
  - Column 3 still produces read, then kbColDrive = 0 and no further reads.
  - Re-enable: next read has kbCol = 01.
- Rst_n pulsed low during SAMPLE of column 6 with key (6,0) debounced pressed:
  - kbColDrive = 0 in the same cycle.
  - After release of reset, column 6 reports kbRow = 0 until 3 new pressed scans.
- Keys (0,0) and (0,6) flip on the same scan:
  - A single read reports kbRow = 7'h41 with one keyChanged pulse.
